// File: rtl/snake_tile_renderer.sv
// Snake playfield tile renderer: 2-bit tile map, wall border, clear sweep.
// Optional FOOD_BLINK_EN: food tiles blink with frame counter bit 4.
module snake_tile_renderer #(
    parameter int unsigned TILE_SHIFT = 4,
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 30,
    parameter logic [7:0]  C_BODY     = 8'h1C,
    parameter logic [7:0]  C_HEAD     = 8'hFC,
    parameter logic [7:0]  C_FOOD     = 8'hE0,
    parameter logic [7:0]  C_WALL     = 8'h92
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] ADDRH,
    input  logic [8:0] ADDRV,
    input  logic       WR_EN,
    input  logic [5:0] WR_X,
    input  logic [4:0] WR_Y,
    input  logic [1:0] WR_TYPE,
    input  logic       CLEAR,
    output logic       BUSY,
    output logic       FRAME_TICK,
    output logic [7:0] COUT
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam logic [10:0] LC    = 11'(COLS);
    localparam logic [10:0] LAST  = 11'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t      r_state;
    logic [10:0] r_sweep;
    logic        r_busy;
    logic [5:0]  r_frame;
    logic        r_zero_d;
    logic        r_tick;
    logic        r_vis;
    logic        r_border;
    logic [7:0]  r_cout;
    logic [1:0]  r_rd;
    logic [1:0]  r_map [0:DEPTH-1];

    logic [5:0]  w_tx;
    logic [4:0]  w_ty;
    logic        w_vis;
    logic        w_border;
    logic        w_zero;
    logic [10:0] w_raddr;
    logic        w_wr_ok;
    logic        w_we;
    logic [10:0] w_waddr;
    logic [1:0]  w_wdata;
    logic        w_food_on;
    logic [7:0]  w_tile_col;
    logic [7:0]  w_col;

    assign w_tx     = 6'(ADDRH >> TILE_SHIFT);
    assign w_ty     = 5'(ADDRV >> TILE_SHIFT);
    assign w_vis    = (ADDRH < 10'd640) && (ADDRV < 9'd480);
    assign w_border = (w_tx == 6'd0) || (w_tx == 6'(COLS - 1)) ||
                      (w_ty == 5'd0) || (w_ty == 5'(ROWS - 1));
    assign w_zero   = (ADDRH == 10'd0) && (ADDRV == 9'd0);
    // Off-screen tile coordinates can exceed the map, so park the read.
    assign w_raddr  = w_vis ? (11'(w_ty) * LC + 11'(w_tx)) : 11'd0;
    assign w_wr_ok  = WR_EN && (WR_X < 6'(COLS)) && (WR_Y < 5'(ROWS));

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sweep;
        w_wdata = 2'd0;
        if (r_state == ST_SWEEP) begin
            w_we = 1'b1;
        end else if (w_wr_ok) begin
            w_we    = 1'b1;
            w_waddr = 11'(WR_Y) * LC + 11'(WR_X);
            w_wdata = WR_TYPE;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we)
            r_map[w_waddr] <= w_wdata;
        r_rd <= r_map[w_raddr];
    end

`ifdef FOOD_BLINK_EN
    assign w_food_on = ~r_frame[4];
`else
    logic w_unused_frame;
    assign w_food_on      = 1'b1;
    assign w_unused_frame = ^r_frame;
`endif

    always_comb begin
        w_tile_col = 8'h00;
        unique case (r_rd)
            2'd0: w_tile_col = 8'h00;
            2'd1: w_tile_col = C_BODY;
            2'd2: w_tile_col = C_HEAD;
            2'd3: w_tile_col = w_food_on ? C_FOOD : 8'h00;
        endcase
        w_col = !r_vis ? 8'h00 : (r_border ? C_WALL : w_tile_col);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_sweep  <= 11'd0;
            r_busy   <= 1'b0;
            r_frame  <= 6'd0;
            r_zero_d <= 1'b0;
            r_tick   <= 1'b0;
            r_vis    <= 1'b0;
            r_border <= 1'b0;
            r_cout   <= 8'h00;
        end else begin
            r_vis    <= w_vis;
            r_border <= w_border;
            r_cout   <= w_col;
            r_zero_d <= w_zero;
            r_tick   <= w_zero && !r_zero_d;
            if (w_zero && !r_zero_d)
                r_frame <= r_frame + 6'd1;
            unique case (r_state)
                ST_IDLE: begin
                    if (CLEAR) begin
                        r_state <= ST_SWEEP;
                        r_sweep <= 11'd0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (r_sweep == LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sweep <= r_sweep + 11'd1;
                    end
                end
            endcase
        end
    end

    assign BUSY       = r_busy;
    assign FRAME_TICK = r_tick;
    assign COUT       = r_cout;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Directed self-checking bench for snake_tile_renderer.
module tb_snake_tile_renderer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [9:0] ADDRH = 10'd700;
    logic [8:0] ADDRV = 9'd10;
    logic       WR_EN = 1'b0;
    logic [5:0] WR_X = 6'd0;
    logic [4:0] WR_Y = 5'd0;
    logic [1:0] WR_TYPE = 2'd0;
    logic       CLEAR = 1'b0;
    logic       BUSY;
    logic       FRAME_TICK;
    logic [7:0] COUT;

    int n_chk = 0;
    int n_err = 0;

    snake_tile_renderer dut (
        .CLK(CLK), .RESET(RESET), .ADDRH(ADDRH), .ADDRV(ADDRV),
        .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y), .WR_TYPE(WR_TYPE),
        .CLEAR(CLEAR), .BUSY(BUSY), .FRAME_TICK(FRAME_TICK), .COUT(COUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic scan(input string tag, input logic [9:0] h,
                        input logic [8:0] v, input logic [7:0] exp);
        @(posedge CLK); #1;
        ADDRH = h;
        ADDRV = v;
        @(posedge CLK);
        @(posedge CLK); #1;
        chk(tag, {24'd0, COUT}, {24'd0, exp});
    endtask

    task automatic wr(input logic [5:0] x, input logic [4:0] y,
                      input logic [1:0] t);
        @(posedge CLK); #1;
        WR_EN = 1'b1; WR_X = x; WR_Y = y; WR_TYPE = t;
        @(posedge CLK); #1;
        WR_EN = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge CLK); #1;
        CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 1300) begin
            n++;
            @(posedge CLK); #1;
        end
        if (BUSY) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cout", {24'd0, COUT}, 32'h0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_tick", {31'd0, FRAME_TICK}, 32'd0);
        RESET = 1'b0;

        scan("scan_0_0", 10'd0, 9'd0, 8'h92);
        scan("scan_700_10", 10'd700, 9'd10, 8'h00);
        scan("scan_639_479", 10'd639, 9'd479, 8'h92);

        // Frame tick: one pulse on entry to (0,0), none while held.
        @(posedge CLK); #1;
        ADDRH = 10'd0; ADDRV = 9'd0;
        @(posedge CLK); #1;
        chk("tick_on", {31'd0, FRAME_TICK}, 32'd1);
        @(posedge CLK); #1;
        chk("tick_held", {31'd0, FRAME_TICK}, 32'd0);

        pulse_clear();
        wait_idle();

        wr(6'd5, 5'd7, 2'd2);
        scan("head_80_112", 10'd80, 9'd112, 8'hFC);
        scan("head_95_127", 10'd95, 9'd127, 8'hFC);
        scan("head_88_120", 10'd88, 9'd120, 8'hFC);
        scan("right_96_112", 10'd96, 9'd112, 8'h00);
        scan("left_79_112", 10'd79, 9'd112, 8'h00);

        wr(6'd6, 5'd8, 2'd1);
        scan("body_6_8", 10'd100, 9'd130, 8'h1C);
        wr(6'd10, 5'd10, 2'd3);
        scan("food_10_10", 10'd165, 9'd165, 8'hE0);
        wr(6'd0, 5'd5, 2'd2);
        scan("border_wr", 10'd5, 9'd85, 8'h92);

        wr(6'd40, 5'd3, 2'd2);
        wr(6'd3, 5'd30, 2'd2);
        wr(6'd63, 5'd3, 2'd2);
        wr(6'd45, 5'd10, 2'd2);
        scan("oob_alias_23_4", 10'd370, 9'd70, 8'h00);
        scan("oob_alias_5_11", 10'd85, 9'd180, 8'h00);
        scan("oob_keep_5_7", 10'd85, 9'd117, 8'hFC);

        // Clear sweep length with re-CLEAR and a write mid-sweep.
        pulse_clear();
        chk("clr_busy", {31'd0, BUSY}, 32'd1);
        cnt = 0;
        while (BUSY && cnt < 2000) begin
            cnt++;
            CLEAR = (cnt == 600);
            WR_EN = (cnt == 700);
            WR_X = 6'd5; WR_Y = 5'd7; WR_TYPE = 2'd1;
            @(posedge CLK); #1;
        end
        CLEAR = 1'b0;
        WR_EN = 1'b0;
        chk("clr_len", cnt, 32'd1200);
        scan("clr_5_7", 10'd85, 9'd117, 8'h00);
        scan("clr_10_10", 10'd165, 9'd165, 8'h00);

        // Reset mid-sweep keeps tiles the sweep has not reached.
        wr(6'd5, 5'd7, 2'd2);
        wr(6'd10, 5'd10, 2'd3);
        wr(6'd20, 5'd20, 2'd1);
        pulse_clear();
        repeat (300) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_cout", {24'd0, COUT}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        scan("mid_5_7", 10'd85, 9'd117, 8'h00);
        scan("mid_10_10", 10'd165, 9'd165, 8'hE0);
        scan("mid_20_20", 10'd325, 9'd325, 8'h1C);
        chk("mid_busy_after", {31'd0, BUSY}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
